// File: rtl/l2_cache_control.sv
// rtl/l2_cache_control.sv - Sequencing FSM for the 4-way, 8-set L2 cache datapath
// Runs hit, write-back and line-fill flows and keeps free-running hit/miss/write-back counters.
module l2_cache_control #(
    parameter int W_CNT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             hit_out,
    input  logic             dirty_out,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             read_data,
    output logic             load_data,
    output logic             load_tag_in,
    output logic             set_valid,
    output logic             set_dirty,
    output logic             clear_dirty,
    output logic             load_lru,
    output logic             pmem_read_address_hold,
    output logic [W_CNT-1:0] hit_count,
    output logic [W_CNT-1:0] miss_count,
    output logic [W_CNT-1:0] wb_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WRITEBACK,
        S_FILL,
        S_RELOAD
    } state_t;

    state_t           state_q, state_d;
    logic             refill_q, refill_d;
    logic [W_CNT-1:0] hit_cnt_q, hit_cnt_d;
    logic [W_CNT-1:0] miss_cnt_q, miss_cnt_d;
    logic [W_CNT-1:0] wb_cnt_q, wb_cnt_d;
    logic             req;
    logic             req_write;

    // Both strobes high is illegal upstream; it resolves to a read.
    assign req       = mem_read | mem_write;
    assign req_write = mem_write & ~mem_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            refill_q   <= refill_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    always_comb begin
        state_d                = state_q;
        refill_d               = refill_q;
        hit_cnt_d              = hit_cnt_q;
        miss_cnt_d             = miss_cnt_q;
        wb_cnt_d               = wb_cnt_q;
        mem_resp               = 1'b0;
        pmem_read              = 1'b0;
        pmem_write             = 1'b0;
        read_data              = 1'b0;
        load_data              = 1'b0;
        load_tag_in            = 1'b0;
        set_valid              = 1'b0;
        set_dirty              = 1'b0;
        clear_dirty            = 1'b0;
        load_lru               = 1'b0;
        pmem_read_address_hold = 1'b0;

        case (state_q)
            S_IDLE: begin
                refill_d = 1'b0;
                if (req) begin
                    read_data = 1'b1;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!req) begin
                    refill_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (hit_out) begin
                    mem_resp  = 1'b1;
                    load_lru  = 1'b1;
                    load_data = req_write;
                    set_dirty = req_write;
                    hit_cnt_d = hit_cnt_q + W_CNT'(1);
                    refill_d  = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    // A request is counted as a miss only on its first pass.
                    if (!refill_q) begin
                        miss_cnt_d = miss_cnt_q + W_CNT'(1);
                    end
                    state_d = dirty_out ? S_WRITEBACK : S_FILL;
                end
            end
            S_WRITEBACK: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    wb_cnt_d = wb_cnt_q + W_CNT'(1);
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                pmem_read              = 1'b1;
                pmem_read_address_hold = 1'b1;
                if (pmem_resp) begin
                    load_data   = 1'b1;
                    load_tag_in = 1'b1;
                    set_valid   = 1'b1;
                    clear_dirty = 1'b1;
                    refill_d    = 1'b1;
                    state_d     = S_RELOAD;
                end
            end
            S_RELOAD: begin
                read_data = 1'b1;
                state_d   = S_CHECK;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are combinational, so they must also be forced low while reset is held.
        if (!rst_n) begin
            mem_resp               = 1'b0;
            pmem_read              = 1'b0;
            pmem_write             = 1'b0;
            read_data              = 1'b0;
            load_data              = 1'b0;
            load_tag_in            = 1'b0;
            set_valid              = 1'b0;
            set_dirty              = 1'b0;
            clear_dirty            = 1'b0;
            load_lru               = 1'b0;
            pmem_read_address_hold = 1'b0;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
endmodule

// File: tb/tb_l2_cache_control.sv
// tb/tb_l2_cache_control.sv - Self-checking bench for l2_cache_control
// Per-request expected strobe traces are built from a cache-contents model and checked every cycle.
module tb_l2_cache_control;
    localparam int W_CNT = 32;

    localparam logic [10:0] E_RESP = 11'h400;
    localparam logic [10:0] E_PRD  = 11'h200;
    localparam logic [10:0] E_PWR  = 11'h100;
    localparam logic [10:0] E_RDD  = 11'h080;
    localparam logic [10:0] E_LDD  = 11'h040;
    localparam logic [10:0] E_LTG  = 11'h020;
    localparam logic [10:0] E_SV   = 11'h010;
    localparam logic [10:0] E_SD   = 11'h008;
    localparam logic [10:0] E_CD   = 11'h004;
    localparam logic [10:0] E_LRU  = 11'h002;
    localparam logic [10:0] E_HOLD = 11'h001;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_read, mem_write, hit_out, dirty_out, pmem_resp;
    logic mem_resp, pmem_read, pmem_write, read_data, load_data, load_tag_in;
    logic set_valid, set_dirty, clear_dirty, load_lru, pmem_read_address_hold;
    logic [W_CNT-1:0] hit_count, miss_count, wb_count;

    always #5 clk = ~clk;

    l2_cache_control #(.W_CNT(W_CNT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit_out(hit_out), .dirty_out(dirty_out), .pmem_resp(pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .read_data(read_data),
        .load_data(load_data), .load_tag_in(load_tag_in), .set_valid(set_valid),
        .set_dirty(set_dirty), .clear_dirty(clear_dirty), .load_lru(load_lru),
        .pmem_read_address_hold(pmem_read_address_hold),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    logic [10:0] dut_vec;
    assign dut_vec = {mem_resp, pmem_read, pmem_write, read_data, load_data, load_tag_in,
                      set_valid, set_dirty, clear_dirty, load_lru, pmem_read_address_hold};

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        hit;
        logic        dty;
        logic        presp;
        logic [10:0] exp;
    } step_t;

    step_t steps[$];

    // Cache contents as the datapath would hold them: tag, valid, dirty, last-use stamp.
    bit [23:0] m_tag   [8][4];
    bit        m_val   [8][4];
    bit        m_dty   [8][4];
    int        m_stamp [8][4];
    int        now_t = 0;
    int        m_hits = 0, m_miss = 0, m_wb = 0;

    int          checks = 0, failures = 0;
    logic        chk_en = 1'b0;
    logic [10:0] exp_vec = '0;
    int          step_idx = 0;
    int          resp_step = -1;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL strobes step=%0d actual=%b required=%b", step_idx, dut_vec, exp_vec);
            end
            if (mem_resp === 1'b1) resp_step = step_idx;
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_cnt();
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_miss);
        chk("wb_count", wb_count, m_wb);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic rd, input logic wr, input logic h, input logic d,
                                 input logic pr, input logic [10:0] e);
        step_t s;
        s.rd = rd; s.wr = wr; s.hit = h; s.dty = d; s.presp = pr; s.exp = e;
        steps.push_back(s);
    endfunction

    task automatic run(input int stop_after);
        step_t s;
        int n;
        n = 0;
        while (steps.size() > 0 && (stop_after < 0 || n < stop_after)) begin
            s = steps.pop_front();
            @(posedge clk);
            #1;
            mem_read = s.rd; mem_write = s.wr; hit_out = s.hit;
            dirty_out = s.dty; pmem_resp = s.presp;
            exp_vec = s.exp; step_idx = n; chk_en = 1'b1;
            n++;
        end
        @(negedge clk);
        steps.delete();
    endtask

    // drop_sel: <0 never withdraw, 0 withdraw at a random memory-phase cycle, >0 withdraw at that step.
    task automatic txn(input logic [31:0] addr, input logic wr, input logic both, input int wbl,
                       input int fl, input int drop_sel, input int gap, input int stop_after);
        int set, hw, v, k, drop_at;
        bit [23:0] tg;
        logic rd_i, is_w, dv, rq, last, commit;
        logic [10:0] wexp;
        set = int'(addr[7:5]);
        tg = addr[31:8];
        rd_i = !wr || both;
        is_w = wr && !both;
        wexp = is_w ? (E_LDD | E_SD) : 11'h000;
        commit = (stop_after < 0);
        hw = -1;
        for (int w = 0; w < 4; w++) if (m_val[set][w] && m_tag[set][w] == tg) hw = w;
        v = 0;
        for (int w = 1; w < 4; w++) if (m_stamp[set][w] < m_stamp[set][v]) v = w;
        dv = m_val[set][v] && m_dty[set][v];
        resp_step = -1;
        push(rd_i, wr, rb(), rb(), 1'b0, E_RDD);
        if (hw >= 0) begin
            push(rd_i, wr, 1'b1, rb(), 1'b0, E_RESP | E_LRU | wexp);
            if (commit) begin
                m_hits++;
                m_stamp[set][hw] = ++now_t;
                if (is_w) m_dty[set][hw] = 1'b1;
            end
        end else begin
            if (drop_sel == 0) drop_at = int'($urandom_range(2, 1 + (dv ? wbl : 0) + fl));
            else if (drop_sel > 0) drop_at = drop_sel;
            else drop_at = -1;
            push(rd_i, wr, 1'b0, dv, 1'b0, 11'h000);
            k = 2;
            if (dv) begin
                for (int i = 0; i < wbl; i++) begin
                    rq = (drop_at < 0) || (k < drop_at);
                    push(rq & rd_i, rq & wr, rb(), rb(), i == wbl - 1, E_PWR);
                    k++;
                end
            end
            for (int i = 0; i < fl; i++) begin
                rq = (drop_at < 0) || (k < drop_at);
                last = (i == fl - 1);
                push(rq & rd_i, rq & wr, rb(), rb(), last,
                     E_PRD | E_HOLD | (last ? (E_LDD | E_LTG | E_SV | E_CD) : 11'h000));
                k++;
            end
            rq = (drop_at < 0);
            push(rq & rd_i, rq & wr, rb(), rb(), 1'b0, E_RDD);
            if (rq) push(rd_i, wr, 1'b1, rb(), 1'b0, E_RESP | E_LRU | wexp);
            else push(1'b0, 1'b0, rb(), rb(), 1'b0, 11'h000);
            if (commit) begin
                m_miss++;
                if (dv) m_wb++;
                m_tag[set][v] = tg;
                m_val[set][v] = 1'b1;
                m_dty[set][v] = 1'b0;
                if (rq) begin
                    m_hits++;
                    m_stamp[set][v] = ++now_t;
                    if (is_w) m_dty[set][v] = 1'b1;
                end
            end
        end
        for (int i = 0; i < gap; i++) push(1'b0, 1'b0, rb(), rb(), 1'b0, 11'h000);
        run(stop_after);
        if (commit) chk_cnt();
    endtask

    initial begin
        int wbl, fl, dsel;
        logic [31:0] a;
        rst_n = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; hit_out = 1'b1; dirty_out = 1'b0; pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_strobes", dut_vec, 0);
        chk_cnt();
        @(posedge clk);
        #1;
        rst_n = 1'b1; mem_read = 1'b0;

        txn(32'h0000_0040, 1'b0, 1'b0, 1, 3, -1, 1, -1);
        chk("cold_read_resp_step", resp_step, 6);
        chk("cold_read_miss_literal", miss_count, 1);
        chk("cold_read_hit_literal", hit_count, 1);
        txn(32'h0000_0040, 1'b0, 1'b0, 1, 1, -1, 1, -1);
        chk("repeat_read_resp_step", resp_step, 1);
        chk("repeat_read_hit_literal", hit_count, 2);
        txn(32'h0000_0040, 1'b1, 1'b0, 1, 1, -1, 1, -1);
        chk("write_hit_resp_step", resp_step, 1);
        for (int k = 1; k <= 5; k++)
            txn(32'h0000_0040 + 32'(k) * 32'h100, 1'b0, 1'b0, 2, int'($urandom_range(1, 4)), -1, 1, -1);
        chk("eviction_wb_literal", wb_count, 1);
        txn(32'h0000_0060, 1'b1, 1'b0, 1, 2, -1, 1, -1);
        chk("write_miss_resp_step", resp_step, 5);
        chk("write_miss_wb_literal", wb_count, 1);

        txn(32'h0000_0340, 1'b1, 1'b0, 1, 1, -1, 1, -1);
        txn(32'h0000_0440, 1'b1, 1'b0, 1, 1, -1, 1, -1);
        txn(32'h0000_0540, 1'b1, 1'b0, 1, 1, -1, 1, -1);
        txn(32'h0000_0240, 1'b1, 1'b0, 1, 1, -1, 1, -1);
        txn(32'h0000_0640, 1'b0, 1'b0, 3, 2, 3, 2, -1);
        chk("withdraw_no_resp", resp_step, -1);
        chk("withdraw_wb_literal", wb_count, 2);

        txn(32'h0000_00A0, 1'b0, 1'b0, 1, 6, -1, 0, 4);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        chk("pmem_read_before_reset", pmem_read, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("pmem_read_async_drop", pmem_read, 0);
        chk("strobes_in_reset", dut_vec, 0);
        m_hits = 0; m_miss = 0; m_wb = 0;
        chk_cnt();
        @(posedge clk);
        #1;
        rst_n = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, rb(), rb(), 1'b0, 11'h000);
        run(-1);
        chk_cnt();

        for (int t = 0; t < 60; t++) begin
            a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 1)) << 5);
            wbl = int'($urandom_range(1, 4));
            fl = int'($urandom_range(1, 4));
            dsel = ($urandom_range(0, 7) == 0) ? 0 : -1;
            txn(a, rb(), ($urandom_range(0, 7) == 0), wbl, fl, dsel, int'($urandom_range(1, 2)), -1);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l2_cache_control.md
# l2_cache_control

Sequencing FSM for the 4-way, 8-set, 256-bit-line L2 cache datapath. Accepts one line-sized read or write from the L1/bus-adapter side. Drives the datapath's array-read, tag/data load, valid/dirty and LRU strobes. Runs write-back and line-fill transactions on physical memory, and keeps free-running hit/miss/write-back event counters for performance analysis.

## Interface
Parameters:
- W_CNT, 32, width of each event counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  upstream line read request, held until mem_resp
- mem_write  in  1  upstream line write request, held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to upstream
- hit_out  in  1  datapath: some way valid with matching tag
- dirty_out  in  1  datapath: LRU way is dirty
- pmem_resp  in  1  memory: transaction complete (one-cycle pulse)
- pmem_read  out  1  memory read request, also to datapath
- pmem_write  out  1  memory write request
- read_data  out  1  datapath: latch tag/data array outputs at next edge
- load_data  out  1  datapath: write data_in into selected way
- load_tag_in  out  1  datapath: write tag into selected way
- set_valid  out  1  datapath: set valid of selected way
- set_dirty  out  1  datapath: set dirty; also selects mem_wdata256 and the hit way
- clear_dirty  out  1  datapath: clear dirty of selected way
- load_lru  out  1  datapath: mark hit way MRU
- pmem_read_address_hold  out  1  datapath: 1 = request tag on pmem_address, 0 = LRU victim tag
- hit_count  out  W_CNT  read/write hits completed
- miss_count  out  W_CNT  misses detected in CHECK
- wb_count  out  W_CNT  dirty write-backs completed

## Operation
- States: IDLE, CHECK, WRITEBACK, FILL, RELOAD.
- IDLE:
  - When mem_read or mem_write is asserted, assert read_data and go to CHECK.
  - Otherwise stay in IDLE with all strobes low.
- CHECK: array outputs are valid this cycle.
  - Read hit: assert mem_resp and load_lru, increment hit_count, go to IDLE.
  - Write hit: assert mem_resp, load_lru, load_data and set_dirty, increment hit_count, go to IDLE.
  - Miss with dirty_out=1: increment miss_count, go to WRITEBACK.
  - Miss with dirty_out=0: increment miss_count, go to FILL.
  - Request deasserted in CHECK: go to IDLE with no strobes.
- WRITEBACK:
  - Assert pmem_write with pmem_read_address_hold=0, so the victim address goes out with the LRU line data.
  - On pmem_resp: increment wb_count, go to FILL.
- FILL:
  - Assert pmem_read with pmem_read_address_hold=1.
  - On pmem_resp, in that same cycle, assert load_data, load_tag_in, set_valid and clear_dirty into the LRU way, then go to RELOAD.
- RELOAD: assert read_data, go to CHECK. The re-check hits, so a write miss completes as a write hit: allocate-on-write.
- One CHECK pass after RELOAD hits; a miss counted once per request. miss_count is not incremented in the post-RELOAD CHECK.
- mem_read and mem_write both high is illegal; the controller treats it as a read.
- Request dropped during WRITEBACK or FILL:
  - The memory transaction still completes, including the fill.
  - Then go to RELOAD→CHECK→IDLE without mem_resp.
- Counters wrap modulo 2^W_CNT and are never cleared except by reset.

## Timing
- Reset (rst_n low, asynchronous, at any time including mid-transaction):
  - State goes to IDLE.
  - Every 1-bit output is 0.
  - All counters are 0.
  - pmem_read/pmem_write drop immediately; the memory side must tolerate an abandoned request.
- All outputs are combinational from state plus inputs. Counters and state are registered.
- Hit latency: request seen in IDLE at cycle 0, mem_resp at cycle 1.
- Clean miss latency: 1 (CHECK) + N (FILL, N = cycles until pmem_resp) + 1 (RELOAD) + 1 (CHECK). mem_resp falls in the final CHECK.
- Dirty miss latency: the clean-miss latency plus the WRITEBACK cycles.
- pmem_read/pmem_write stay high continuously from state entry through the pmem_resp cycle, and are low the following cycle.
- Back-to-back requests: after mem_resp, at least one IDLE cycle before the next CHECK.
- Upstream must drop the request within one cycle of mem_resp. If it stays high, the controller treats it as a new request.

## Test plan
- Cold read 0x0000_0040, memory responds after 3 cycles:
  - pmem_read high for 3 cycles, hold=1.
  - load_data/load_tag_in/set_valid/clear_dirty pulse on the pmem_resp cycle.
  - mem_resp at cycle 6.
  - miss_count=1, hit_count=1.
- Repeat read 0x0000_0040: mem_resp in cycle 1, load_lru=1, no pmem activity, hit_count=2.
- Write hit to 0x0000_0040:
  - The CHECK cycle has set_dirty=load_data=load_lru=mem_resp=1.
  - Then five fills to set 2 (addresses 0x40+0x100·k, k=1..5) force eviction.
  - Expect exactly one pmem_write with hold=0, then a pmem_read. wb_count=1.
- Write miss to a clean victim: FILL then RELOAD then CHECK with set_dirty=1 and mem_resp. No pmem_write.
- Reset asserted mid-FILL with pmem_read high:
  - pmem_read drops asynchronously, all counters read 0.
  - After release the controller sits in IDLE with no strobes.
- Request withdrawn during WRITEBACK:
  - Write-back and fill complete.
  - No mem_resp, and return to IDLE within 2 cycles after the fill's pmem_resp.
